// File: rtl/vga_pkg.sv
// Shared VGA raster definitions: default 640x480@60 timing, colour type and the
// raw per-pixel sync/enable bundle carried through the latency-matching pipe.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_PIPE     = 2;
  localparam int DEF_CW       = 10;

  // RRGGBB, two bits per channel
  typedef logic [5:0] rgb_t;

  // Undelayed raster qualifiers derived from the current x/y position
  typedef struct packed {
    logic hs;
    logic vs;
    logic active;
  } raster_t;

  function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register with a synchronous reset value; DEPTH=0 is a wire.
module vga_delay_line #(
  parameter int              DEPTH   = 2,
  parameter int              WIDTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, rst, en};
      assign q = d;
    end else begin : g_shift
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
        end else if (en) begin
          stage[0] <= d;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign q = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_sync_gen.sv
// Parametrised VGA raster timing generator. Syncs, display enable and colour are
// delayed so they line up with a pixel source that answers PIPE steps late.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE  = DEF_H_ACTIVE,
  parameter int   H_FP      = DEF_H_FP,
  parameter int   H_SYNC    = DEF_H_SYNC,
  parameter int   H_BP      = DEF_H_BP,
  parameter int   V_ACTIVE  = DEF_V_ACTIVE,
  parameter int   V_FP      = DEF_V_FP,
  parameter int   V_SYNC    = DEF_V_SYNC,
  parameter int   V_BP      = DEF_V_BP,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int   PIPE      = DEF_PIPE,
  parameter int   CW        = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  input  rgb_t          rgb_in,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output rgb_t          rgb_out
);

  localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  generate
    if ((H_TOTAL > (1 << CW)) || (V_TOTAL > (1 << CW)) || (PIPE < 0) || (PIPE > 7)) begin : g_param_check
      $error("vga_sync_gen: CW too narrow for the raster totals or PIPE outside 0..7");
    end
  endgenerate

  // Position counters and wrap strobes; strobes are single-clk even at low pix_en rates.
  always_ff @(posedge clk) begin
    if (rst) begin
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_en) begin
        if (x == H_LAST) begin
          x          <= '0;
          line_start <= 1'b1;
          if (y == V_LAST) begin
            y           <= '0;
            frame_start <= 1'b1;
          end else begin
            y <= y + 1'b1;
          end
        end else begin
          x <= x + 1'b1;
        end
      end
    end
  end

  // Compare at 32 bits so a zero back porch cannot overflow the CW-wide bounds.
  logic [31:0] xw;
  logic [31:0] yw;
  raster_t     raw;
  raster_t     raw_d;

  always_comb begin
    xw         = 32'(x);
    yw         = 32'(y);
    raw.active = (xw < 32'(H_ACTIVE)) && (yw < 32'(V_ACTIVE));
    raw.hs     = (xw >= 32'(H_ACTIVE + H_FP)) && (xw < 32'(H_ACTIVE + H_FP + H_SYNC));
    raw.vs     = (yw >= 32'(V_ACTIVE + V_FP)) && (yw < 32'(V_ACTIVE + V_FP + V_SYNC));
  end

  vga_delay_line #(
    .DEPTH   (PIPE),
    .WIDTH   ($bits(raster_t)),
    .RST_VAL ('0)
  ) u_delay (
    .clk (clk),
    .rst (rst),
    .en  (pix_en),
    .d   (raw),
    .q   (raw_d)
  );

  // Final register: rgb_in arrives together with the delayed qualifiers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync   <= ~HSYNC_POL;
      vsync   <= ~VSYNC_POL;
      de      <= 1'b0;
      rgb_out <= '0;
    end else if (pix_en) begin
      hsync   <= raw_d.hs ? HSYNC_POL : ~HSYNC_POL;
      vsync   <= raw_d.vs ? VSYNC_POL : ~VSYNC_POL;
      de      <= raw_d.active;
      rgb_out <= raw_d.active ? rgb_in : '0;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: two small-raster instances (PIPE=2 active-low syncs,
// PIPE=0 active-high syncs) checked against a step-count raster model.
module tb_vga_sync_gen;
  import vga_pkg::*;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int PIPE_A = 2;
  localparam int PIPE_B = 0;
  localparam int CW = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_en = 1'b0;
  always #5 clk = ~clk;

  rgb_t rgb_in_a = '0;
  rgb_t rgb_in_b = '0;
  logic [CW-1:0] a_x, a_y, b_x, b_y;
  logic a_ls, a_fs, a_hs, a_vs, a_de;
  logic b_ls, b_fs, b_hs, b_vs, b_de;
  rgb_t a_rgb, b_rgb;

  vga_sync_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIPE(PIPE_A), .CW(CW)
  ) dut_a (
    .clk(clk), .rst(rst), .pix_en(pix_en), .rgb_in(rgb_in_a),
    .x(a_x), .y(a_y), .line_start(a_ls), .frame_start(a_fs),
    .hsync(a_hs), .vsync(a_vs), .de(a_de), .rgb_out(a_rgb)
  );

  vga_sync_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIPE(PIPE_B), .CW(CW)
  ) dut_b (
    .clk(clk), .rst(rst), .pix_en(pix_en), .rgb_in(rgb_in_b),
    .x(b_x), .y(b_y), .line_start(b_ls), .frame_start(b_fs),
    .hsync(b_hs), .vsync(b_vs), .de(b_de), .rgb_out(b_rgb)
  );

  int checks = 0;
  int failures = 0;

  // reference model: s = pixel steps since reset; colour table per raster position
  int   s = 0;
  bit   adv = 1'b0;
  rgb_t colour [FT];

  function automatic int pos_of(input int st);
    int p;
    p = st % FT;
    if (p < 0) p += FT;
    return p;
  endfunction

  function automatic bit in_active(input int p);
    return ((p % HT) < HA) && ((p / HT) < VA);
  endfunction

  function automatic bit in_hs(input int p);
    return ((p % HT) >= HA + HF) && ((p % HT) < HA + HF + HS);
  endfunction

  function automatic bit in_vs(input int p);
    return ((p / HT) >= VA + VF) && ((p / HT) < VA + VF + VS);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_one(input string who, input int pipe, input bit pol,
                           input logic [CW-1:0] ox, input logic [CW-1:0] oy,
                           input logic ohs, input logic ovs, input logic ode,
                           input rgb_t orgb, input logic ols, input logic ofs);
    int   h;
    int   q;
    bit   e_de, e_hs, e_vs;
    rgb_t e_rgb;
    h     = s - pipe - 1;
    e_de  = 1'b0;
    e_hs  = ~pol;
    e_vs  = ~pol;
    e_rgb = '0;
    if (h >= 0) begin
      q     = pos_of(h);
      e_de  = in_active(q);
      e_hs  = in_hs(q) ? pol : ~pol;
      e_vs  = in_vs(q) ? pol : ~pol;
      e_rgb = e_de ? colour[q] : '0;
    end
    chk({who, ".x"},           16'(ox),   16'(pos_of(s) % HT));
    chk({who, ".y"},           16'(oy),   16'(pos_of(s) / HT));
    chk({who, ".hsync"},       16'(ohs),  16'(e_hs));
    chk({who, ".vsync"},       16'(ovs),  16'(e_vs));
    chk({who, ".de"},          16'(ode),  16'(e_de));
    chk({who, ".rgb_out"},     16'(orgb), 16'(e_rgb));
    chk({who, ".line_start"},  16'(ols),  16'(adv && (s % HT == 0)));
    chk({who, ".frame_start"}, 16'(ofs),  16'(adv && (s % FT == 0)));
  endtask

  // driver: one clk with the given enable/reset, model update, then check both DUTs
  task automatic cyc(input bit en, input bit r);
    pix_en = en;
    rst    = r;
    @(posedge clk);
    if (r) begin
      s   = 0;
      adv = 1'b0;
    end else if (en) begin
      s++;
      adv = 1'b1;
    end else begin
      adv = 1'b0;
    end
    #1;
    check_one("a", PIPE_A, 1'b0, a_x, a_y, a_hs, a_vs, a_de, a_rgb, a_ls, a_fs);
    check_one("b", PIPE_B, 1'b1, b_x, b_y, b_hs, b_vs, b_de, b_rgb, b_ls, b_fs);
    rgb_in_a = colour[pos_of(s - PIPE_A)];
    rgb_in_b = colour[pos_of(s - PIPE_B)];
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_de_a, n_hs_a, n_vs_a, n_de_b, n_hs_b, n_vs_b, n_ls_b, n_fs_b, n_first;
    for (int i = 0; i < FT; i++) colour[i] = rgb_t'($urandom_range(0, 63));

    // reset held 3 clks with pix_en high
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1);
    chk("rst.a_hsync", 16'(a_hs), 16'd1);
    chk("rst.a_vsync", 16'(a_vs), 16'd1);
    chk("rst.b_hsync", 16'(b_hs), 16'd0);

    cyc(1'b1, 1'b0);
    chk("release.a_x", 16'(a_x), 16'd1);

    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0);

    // one full frame worth of full-rate steps: count asserted outputs
    n_de_a = 0; n_hs_a = 0; n_vs_a = 0;
    n_de_b = 0; n_hs_b = 0; n_vs_b = 0; n_ls_b = 0; n_fs_b = 0;
    for (int i = 0; i < FT; i++) begin
      cyc(1'b1, 1'b0);
      n_de_a += int'(a_de);
      n_hs_a += int'(!a_hs);
      n_vs_a += int'(!a_vs);
      n_de_b += int'(b_de);
      n_hs_b += int'(b_hs);
      n_vs_b += int'(b_vs);
      n_ls_b += int'(b_ls);
      n_fs_b += int'(b_fs);
    end
    chk("frame.a_de_count",    16'(n_de_a), 16'(HA * VA));
    chk("frame.a_hsync_count", 16'(n_hs_a), 16'(HS * VT));
    chk("frame.a_vsync_count", 16'(n_vs_a), 16'(VS * HT));
    chk("frame.b_de_count",    16'(n_de_b), 16'(HA * VA));
    chk("frame.b_hsync_count", 16'(n_hs_b), 16'(HS * VT));
    chk("frame.b_vsync_count", 16'(n_vs_b), 16'(VS * HT));
    chk("frame.b_line_starts", 16'(n_ls_b), 16'(VT));
    chk("frame.b_frame_starts", 16'(n_fs_b), 16'd1);

    for (int i = 0; i < 2 * FT; i++) cyc(1'b1, 1'b0);

    // half rate, then a 10-clk stall mid-line
    for (int i = 0; i < 40; i++) cyc(i % 2 == 0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0);

    // random enable pattern
    for (int i = 0; i < 300; i++) cyc($urandom_range(0, 2) != 0, 1'b0);

    // mid-frame reset at x=5, y=2
    for (int i = 0; i < FT + 2; i++) begin
      if (pos_of(s) == 2 * HT + 5) break;
      cyc(1'b1, 1'b0);
    end
    chk("pre_rst.a_x", 16'(a_x), 16'd5);
    chk("pre_rst.a_y", 16'(a_y), 16'd2);
    cyc(1'b1, 1'b1);
    chk("mid_rst.a_fs", 16'(a_fs), 16'd0);
    n_first = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b0);
      n_first++;
      if (a_de) break;
    end
    chk("first_de_steps", 16'(n_first), 16'(PIPE_A + 1));

    for (int i = 0; i < 200; i++) cyc($urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Parametrised VGA raster timing generator with a latency-matched pixel output stage. It is the next-generation replacement for the fixed 640x480 hsync/vsync/1-bit-pixel generator inside our TinyTapeout tops. Timing, sync polarity, pixel-rate enable and pixel-source pipeline depth are now generic, and it adds a data-enable output, line/frame strobes and 6-bit RRGGBB colour with blanking. A pixel source reads `x`/`y`, returns colour on `rgb_in` after `PIPE` pixel steps, and this block aligns that colour with the syncs.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch
- `H_SYNC`, 96: hsync width
- `H_BP`, 48: horizontal back porch
- `V_ACTIVE`, 480: visible lines
- `V_FP`, 10: vertical front porch
- `V_SYNC`, 2: vsync width
- `V_BP`, 33: vertical back porch
- `HSYNC_POL`, 0: asserted level of hsync (0 = active-low)
- `VSYNC_POL`, 0: asserted level of vsync
- `PIPE`, 2: pixel-source latency in pixel steps (0..7)
- `CW`, 10: counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports (all registered outputs):
- `clk`  in  1  single clock
- `rst`  in  1  synchronous, active-high reset
- `pix_en`  in  1  pixel-step enable; all state advances only when high
- `rgb_in`  in  6  colour for the pixel shown on `x`/`y` `PIPE` steps earlier
- `x`  out  CW  horizontal counter
- `y`  out  CW  vertical counter
- `line_start`  out  1  one-clk pulse after `x` wraps to 0
- `frame_start`  out  1  one-clk pulse after `x` and `y` both wrap to 0
- `hsync`  out  1  aligned horizontal sync
- `vsync`  out  1  aligned vertical sync
- `de`  out  1  aligned display-enable
- `rgb_out`  out  6  aligned colour, forced to 0 when `de` is low

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- On a clk edge with `pix_en`=1: `x` increments. At H_TOTAL-1, `x` wraps to 0 and `y` increments. At V_TOTAL-1, `y` wraps to 0.
- With `pix_en`=0, every register holds, including the delay line. Strobes are 0 in that cycle.
- Raw signals from the counter values:
  - active = (x < H_ACTIVE) && (y < V_ACTIVE)
  - hs = (H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC)
  - vs = (V_ACTIVE+V_FP ≤ y < V_ACTIVE+V_FP+V_SYNC)
  - vs depends only on `y`, not on `x`.
- Raw {hs, vs, active} passes through a `PIPE`-deep enable-gated delay line. A final output register, also updated on `pix_en`, produces:
  - `hsync` = hs_d ? HSYNC_POL : ~HSYNC_POL (`vsync` likewise)
  - `de` = active_d
  - `rgb_out` = active_d ? `rgb_in` : 0
- `line_start` is asserted on the clk cycle immediately after the edge on which `x` wrapped to 0.
- `frame_start` is asserted on the clk cycle immediately after the edge on which both `x` and `y` wrapped to 0; `line_start` is also high that cycle. Neither pulse exceeds one clk.
- Reset takes priority over `pix_en`. It sets:
  - `x`=`y`=0 and all delay stages to the inactive/deasserted state
  - `hsync`=~HSYNC_POL, `vsync`=~VSYNC_POL, `de`=0, `rgb_out`=0
  - `line_start`=`frame_start`=0; reset itself never produces a strobe
- Reset mid-frame restarts the raster at (0,0) on the next clk. The first post-reset `de` appears PIPE+1 pix_en steps later.

## Timing
- Latency: position p shown on `x`/`y` at pixel step n appears on `hsync`/`vsync`/`de`/`rgb_out` after pixel step n+PIPE+1.
- `rgb_in` is sampled on the pix_en edge PIPE steps after `x`/`y` present the pixel it belongs to.
- For a full line, `hsync` is asserted for exactly H_SYNC pixel steps and `de` for exactly H_ACTIVE. For a full frame, `vsync` is asserted for exactly V_SYNC·H_TOTAL pixel steps.
- With `pix_en` tied high, one pixel per clk. With `pix_en` at a 1-in-N rate, every output is stretched N clks; strobes remain 1 clk.

## Structure
- Package `vga_pkg` holds:
  - the default 640x480@60 timing as localparams
  - a `vga_total` function (sum of four parameters)
  - a `rgb_t` 6-bit typedef (RRGGBB)
- Sub-module `vga_delay_line`: parametrised DEPTH/WIDTH shift register with enable and synchronous reset value. DEPTH=0 is a pass-through.
- Elaboration assertion: CW is wide enough for both totals, and PIPE ≤ 7.

## Test plan
- Reset: hold `rst` for 3 clks with `pix_en`=1 → `x`=`y`=0, `hsync`=`vsync`=1, `de`=0, `rgb_out`=0, no strobes. Release → `x`=1 after the first edge.
- Small timing (H 4/1/2/1, V 3/1/1/1, PIPE 0, `pix_en`=1): per line `de`=1,1,1,1,0,0,0,0 and `hsync` low on steps 5–6 only. `vsync` low for exactly 8 clks per 48-clk frame. `frame_start` fires every 48 clks.
- Alignment: PIPE=2, pixel source returns `rgb_in`={x[2:0],y[2:0]} delayed 2 steps → `rgb_out` equals the same pattern for every `de`=1 pixel and is 0 in blanking.
- Half rate: `pix_en` toggling every clk → outputs hold 2 clks each; `line_start` is 1 clk wide. `pix_en` held 0 for 10 clks mid-line → no output changes.
- Polarity: HSYNC_POL=1, VSYNC_POL=1 → reset levels 0; pulses are high with the same widths as the small-timing case.
- Mid-frame reset at `x`=5, `y`=2 → next clk `x`=`y`=0, no `frame_start`. First `de`=1 arrives PIPE+1 steps after release.
